decod3to8ot: RTL and testbench
==============================

DECOD3TO8OT -- requirements
Module: decod3to8ot

Interface
REQ-001 Parameter OUT_INV, default 0: 0 = active-high one-hot outputs; 1 = all eight D outputs inverted (active-low one-cold).
REQ-002 Parameter CNT_W, default 8: width of change counter chg_cnt.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 A2, A1, A0  input  1 each  3-bit code; A2 = MSB, code = {A2,A1,A0}.
REQ-007 en  input  1  decode enable.
REQ-008 D0..D7  output  1 each  registered decoded lines; Dn asserted when code = n.
REQ-009 valid  output  1  high when D0..D7 hold a decode result.
REQ-010 code_q  output  3  registered copy of the last decoded code.
REQ-011 chg_cnt  output  CNT_W  saturating count of decoded-code changes.
REQ-012 err  output  1  registered one-hot integrity flag.

Function
REQ-013 All outputs SHALL be registered on the rising clk edge; combinational input-to-output paths are not permitted.
REQ-014 With en=1 at an edge, Dn SHALL become asserted for n = {A2,A1,A0}, all other D deasserted, and valid SHALL become 1; latency is exactly 1 cycle.
REQ-015 Asserted level is 1 when OUT_INV=0 and 0 when OUT_INV=1; exactly one D line is asserted while valid=1.
REQ-016 With en=1, code_q SHALL load {A2,A1,A0}.
REQ-017 chg_cnt SHALL increment by 1 at an edge with en=1, valid=1 and {A2,A1,A0} != code_q; it SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 The first decode after reset (valid=0) SHALL NOT increment chg_cnt.
REQ-019 err SHALL be 1 in the cycle after the registered D vector, normalised to active-high, is not one-hot while valid=1; otherwise err=0.
REQ-020 With en=0, behaviour SHALL follow the Configuration section; code_q and chg_cnt hold.
REQ-021 Inputs SHALL be sampled only at the rising edge; glitches between edges have no effect.

Reset
REQ-022 When rst=1 at an edge, rst SHALL take priority over en.
REQ-023 On reset, all D lines SHALL be deasserted: 0 with OUT_INV=0, 1 with OUT_INV=1.
REQ-024 On reset, valid=0, code_q=3'b000, chg_cnt=0 and err=0.
REQ-025 A reset mid-sequence SHALL discard the current decode; decoding resumes on the first edge with rst=0 and en=1.
REQ-026 Before the first clk edge with rst=1, output values are undefined.

Configuration
REQ-027 Macro DECOD3TO8OT_HOLD_EN SHALL control the en=0 behaviour.
REQ-028 With DECOD3TO8OT_HOLD_EN defined, en=0 SHALL hold D0..D7 and valid at their previous values.
REQ-029 Without DECOD3TO8OT_HOLD_EN, en=0 SHALL deassert all D lines at the next edge and clear valid to 0.

Verification
REQ-030 rst=1 for 2 cycles, then rst=0 and en=0 -> all D=0, valid=0, chg_cnt=0, err=0 (OUT_INV=0).
REQ-031 en=1, apply codes 000..111, one per cycle -> one cycle later D0..D7 respectively high alone; valid=1; code_q tracks the input; chg_cnt=7.
REQ-032 OUT_INV=1, code 101 -> D5=0 and all other D=1 one cycle later.
REQ-033 Hold code 011 for 4 cycles, then 011 -> 100 -> chg_cnt increments only on the change, by 1.
REQ-034 CNT_W=2, 5 code changes -> chg_cnt saturates at 3.
REQ-035 Decode 110, then en=0 -> D6 stays high with the macro defined; all D=0 and valid=0 without it. Assert rst mid-run -> reset values at the next edge.

Source files
------------

// File: rtl/decod3to8ot.sv
// Registered 3-to-8 decoder with change counter and one-hot integrity flag.
// Macro DECOD3TO8OT_HOLD_EN: when defined, en=0 holds D0..D7/valid instead of clearing them.
module decod3to8ot #(
    parameter logic        OUT_INV = 1'b0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A2,
    input  logic             A1,
    input  logic             A0,
    input  logic             en,
    output logic             D0,
    output logic             D1,
    output logic             D2,
    output logic             D3,
    output logic             D4,
    output logic             D5,
    output logic             D6,
    output logic             D7,
    output logic             valid,
    output logic [2:0]       code_q,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0]       codeIn;
    logic [7:0]       dOut_q, dOut_d;
    logic [7:0]       dIdle;
    logic [7:0]       dNorm;
    logic             valid_q, valid_d;
    logic [2:0]       codeReg_q, codeReg_d;
    logic [CNT_W-1:0] chgCnt_q, chgCnt_d;
    logic             err_q, err_d;

    assign codeIn = {A2, A1, A0};
    // dOut_q holds physical pin levels; dNorm is the active-high view used by the integrity check.
    assign dIdle  = {8{OUT_INV}};
    assign dNorm  = dOut_q ^ dIdle;

    always_comb begin
        dOut_d    = dOut_q;
        valid_d   = valid_q;
        codeReg_d = codeReg_q;
        chgCnt_d  = chgCnt_q;
        err_d     = valid_q && !$onehot(dNorm);
        if (en) begin
            dOut_d    = (8'b0000_0001 << codeIn) ^ dIdle;
            valid_d   = 1'b1;
            codeReg_d = codeIn;
            // Only a change relative to a previously valid decode counts; saturate, never wrap.
            if (valid_q && (codeIn != codeReg_q) && (chgCnt_q != CNT_MAX)) begin
                chgCnt_d = chgCnt_q + CNT_ONE;
            end
        end else begin
`ifdef DECOD3TO8OT_HOLD_EN
            dOut_d  = dOut_q;
            valid_d = valid_q;
`else
            dOut_d  = dIdle;
            valid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dOut_q    <= dIdle;
            valid_q   <= 1'b0;
            codeReg_q <= 3'b000;
            chgCnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            dOut_q    <= dOut_d;
            valid_q   <= valid_d;
            codeReg_q <= codeReg_d;
            chgCnt_q  <= chgCnt_d;
            err_q     <= err_d;
        end
    end

    assign {D7, D6, D5, D4, D3, D2, D1, D0} = dOut_q;
    assign valid   = valid_q;
    assign code_q  = codeReg_q;
    assign chg_cnt = chgCnt_q;
    assign err     = err_q;

endmodule

// File: tb/tb_decod3to8ot.sv
// Scoreboard bench for decod3to8ot: default, inverted-output and 2-bit-counter instances share stimulus.
module tb_decod3to8ot;

    logic clk = 1'b0;
    logic rst, A2, A1, A0, en;

    logic [7:0] dA, dB, dC;
    logic       validA, validB, validC;
    logic [2:0] codeA, codeB, codeC;
    logic [7:0] cntA, cntB;
    logic [1:0] cntC;
    logic       errA, errB, errC;

    typedef struct {
        logic [7:0] d;
        logic       valid;
        logic [2:0] code;
        logic [7:0] cnt;
        logic [1:0] cntSat;
        logic       err;
    } expT;

    expT sb[$];

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0] mD;
    logic       mValid;
    logic [2:0] mCode;
    logic [7:0] mCnt;
    logic [1:0] mSat;
    logic       mErr;

    always #5 clk = ~clk;

    decod3to8ot dutA (
        .clk(clk), .rst(rst), .A2(A2), .A1(A1), .A0(A0), .en(en),
        .D0(dA[0]), .D1(dA[1]), .D2(dA[2]), .D3(dA[3]),
        .D4(dA[4]), .D5(dA[5]), .D6(dA[6]), .D7(dA[7]),
        .valid(validA), .code_q(codeA), .chg_cnt(cntA), .err(errA)
    );

    decod3to8ot #(.OUT_INV(1'b1)) dutB (
        .clk(clk), .rst(rst), .A2(A2), .A1(A1), .A0(A0), .en(en),
        .D0(dB[0]), .D1(dB[1]), .D2(dB[2]), .D3(dB[3]),
        .D4(dB[4]), .D5(dB[5]), .D6(dB[6]), .D7(dB[7]),
        .valid(validB), .code_q(codeB), .chg_cnt(cntB), .err(errB)
    );

    decod3to8ot #(.CNT_W(2)) dutC (
        .clk(clk), .rst(rst), .A2(A2), .A1(A1), .A0(A0), .en(en),
        .D0(dC[0]), .D1(dC[1]), .D2(dC[2]), .D3(dC[3]),
        .D4(dC[4]), .D5(dC[5]), .D6(dC[6]), .D7(dC[7]),
        .valid(validC), .code_q(codeC), .chg_cnt(cntC), .err(errC)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one edge and queue what the DUTs must show afterwards.
    task automatic applyStimulus(input logic r, input logic e, input logic [2:0] c);
        expT x;
        rst = r;
        en  = e;
        {A2, A1, A0} = c;
        if (r) begin
            mD = 8'h00; mValid = 1'b0; mCode = 3'b000; mCnt = 8'h00; mSat = 2'b00; mErr = 1'b0;
        end else begin
            mErr = mValid && !$onehot(mD);
            if (e) begin
                if (mValid && (c != mCode)) begin
                    if (mCnt != 8'hFF) mCnt = mCnt + 8'h01;
                    if (mSat != 2'b11) mSat = mSat + 2'b01;
                end
                mD     = 8'h01 << c;
                mValid = 1'b1;
                mCode  = c;
            end else begin
`ifndef DECOD3TO8OT_HOLD_EN
                mD     = 8'h00;
                mValid = 1'b0;
`endif
            end
        end
        x.d = mD; x.valid = mValid; x.code = mCode; x.cnt = mCnt; x.cntSat = mSat; x.err = mErr;
        sb.push_back(x);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkOutput();
        expT x;
        if (sb.size() == 0) begin
            checkVal("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        x = sb.pop_front();
        checkVal("dA",     {24'd0, dA},     {24'd0, x.d});
        checkVal("dB_inv", {24'd0, dB},     {24'd0, ~x.d});
        checkVal("dC",     {24'd0, dC},     {24'd0, x.d});
        checkVal("validA", {31'd0, validA}, {31'd0, x.valid});
        checkVal("validB", {31'd0, validB}, {31'd0, x.valid});
        checkVal("codeA",  {29'd0, codeA},  {29'd0, x.code});
        checkVal("codeB",  {29'd0, codeB},  {29'd0, x.code});
        checkVal("cntA",   {24'd0, cntA},   {24'd0, x.cnt});
        checkVal("cntB",   {24'd0, cntB},   {24'd0, x.cnt});
        checkVal("cntC",   {30'd0, cntC},   {30'd0, x.cntSat});
        checkVal("errA",   {31'd0, errA},   {31'd0, x.err});
        checkVal("errB",   {31'd0, errB},   {31'd0, x.err});
        checkVal("errC",   {31'd0, errC},   {31'd0, x.err});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        mD = 8'h00; mValid = 1'b0; mCode = 3'b000; mCnt = 8'h00; mSat = 2'b00; mErr = 1'b0;
        rst = 1'b1; en = 1'b0; {A2, A1, A0} = 3'b000;

        // Reset for two cycles, then idle with en low.
        applyStimulus(1'b1, 1'b0, 3'b000);
        applyStimulus(1'b1, 1'b1, 3'b111);
        applyStimulus(1'b0, 1'b0, 3'b101);

        // Walk all eight codes; the first decode after reset does not count.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 3'(i));
        checkVal("cnt_after_walk", {24'd0, cntA}, 32'd7);
        checkVal("sat_after_walk", {30'd0, cntC}, 32'd3);

        // Hold 011, then step to 100: counter moves once per change only.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 3'b011);
        applyStimulus(1'b0, 1'b1, 3'b100);
        checkVal("cnt_after_hold", {24'd0, cntA}, 32'd9);

        // Inverted instance on code 101: only D5 low.
        applyStimulus(1'b0, 1'b1, 3'b101);
        checkVal("inv_code5", {24'd0, dB}, 32'hDF);

        // Decode 110 then drop en.
        applyStimulus(1'b0, 1'b1, 3'b110);
        applyStimulus(1'b0, 1'b0, 3'b001);
        applyStimulus(1'b0, 1'b0, 3'b010);

        // Mid-run reset overrides en; decoding resumes without counting the first result.
        applyStimulus(1'b0, 1'b1, 3'b001);
        applyStimulus(1'b1, 1'b1, 3'b111);
        applyStimulus(1'b0, 1'b1, 3'b010);
        applyStimulus(1'b0, 1'b1, 3'b010);
        applyStimulus(1'b0, 1'b1, 3'b110);

        // Random codes and enables.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
        end

        // Drive the full counter towards saturation is long; check the narrow one stays pinned.
        checkVal("sat_pinned", {30'd0, cntC}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
